uart_tx: RTL and testbench

UART transmitter that serialises bytes onto a single 8N1 line at one of five selectable baud rates from the 50 MHz system clock. It is the companion stage to the UART receiver. In loopback and board benches, `uart_tx_o` drives the receiver's serial input directly. Both ends therefore use the same `buad_set_i` encoding and the same 16x-oversampling divisor constants, so a frame sent here is sampled bit-centred by the receiver.

---
 rtl/uart_tx_pkg.sv | 25 ++
 rtl/uart_tx_fifo.sv | 40 ++++
 rtl/uart_tx.sv | 103 ++++++++++
 tb/tb_uart_tx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared 16x-oversampling baud divisors (N-1) and FSM state encodings
// Divisor constants must stay identical to the receiver's so loopback frames sample bit-centred.
package uart_tx_pkg;

    localparam logic [8:0] BUAD_9600   = 9'd324;
    localparam logic [8:0] BUAD_19200  = 9'd161;
    localparam logic [8:0] BUAD_38400  = 9'd80;
    localparam logic [8:0] BUAD_57600  = 9'd53;
    localparam logic [8:0] BUAD_115200 = 9'd26;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } state_t;

    function automatic logic [8:0] buad_div(input logic [2:0] sel);
        return sel == 3'd1 ? BUAD_9600  :
               sel == 3'd2 ? BUAD_19200 :
               sel == 3'd3 ? BUAD_38400 :
               sel == 3'd4 ? BUAD_57600 : BUAD_115200;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 4-entry, 8-bit input FIFO for uart_tx (used only with UART_TX_FIFO_EN)
module uart_tx_fifo (
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);

    logic [7:0] mem [4];
    logic [1:0] wptr, rptr;
    logic [2:0] count;
    logic       do_push, do_pop;

    assign full    = count == 3'd4;
    assign empty   = count == 3'd0;
    assign rdata   = mem[rptr];
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + 2'(do_push);
            rptr  <= rptr + 2'(do_pop);
            count <= count + 3'(do_push) - 3'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter, five selectable baud rates from a 50 MHz clock
// Optional 4-entry input FIFO enabled by defining UART_TX_FIFO_EN.
module uart_tx
    import uart_tx_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic [2:0] buad_set_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       uart_tx_o,
    output logic       tx_busy_o,
    output logic       tx_done_o
);

    state_t     state, state_nx;
    logic [8:0] div_cnt, div_max, div_sel;
    logic [3:0] tick_cnt;
    logic [2:0] bit_idx;
    logic [7:0] shift, next_byte;
    logic       tick, bit_end, load_pt, avail, take;

    assign div_sel = buad_div(buad_set_i);
    assign tick    = div_cnt == 9'd0;
    assign bit_end = tick && tick_cnt == 4'd15;
    assign take    = load_pt && avail;

`ifdef UART_TX_FIFO_EN
    logic       f_full, f_empty, f_push, f_pop;
    logic [7:0] f_rdata;

    assign tx_ready_o = !f_full;
    assign load_pt    = state == IDLE || (state == STOP && bit_end);
    assign avail      = !f_empty || (tx_valid_i && tx_ready_o);
    assign next_byte  = f_empty ? tx_data_i : f_rdata;
    assign f_pop      = take && !f_empty;
    // An accepted byte arriving with an empty FIFO at a load point bypasses it
    assign f_push     = tx_valid_i && tx_ready_o && !(take && f_empty);

    uart_tx_fifo u_fifo (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .push  (f_push),
        .wdata (tx_data_i),
        .pop   (f_pop),
        .rdata (f_rdata),
        .full  (f_full),
        .empty (f_empty)
    );
`else
    assign tx_ready_o = state == IDLE;
    assign load_pt    = state == IDLE;
    assign avail      = tx_valid_i;
    assign next_byte  = tx_data_i;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = take ? START : IDLE;
            START:   state_nx = bit_end ? DATA : START;
            DATA:    state_nx = (bit_end && bit_idx == 3'd7) ? STOP : DATA;
            STOP:    state_nx = bit_end ? (take ? START : IDLE) : STOP;
            default: state_nx = IDLE;
        endcase
    end

    // Divisor is preloaded with N-1 at frame start so each bit spans exactly 16*N cycles
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            div_cnt   <= '0;
            div_max   <= '0;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            uart_tx_o <= 1'b1;
            tx_busy_o <= 1'b0;
            tx_done_o <= 1'b0;
        end else begin
            state     <= state_nx;
            uart_tx_o <= state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
            tx_busy_o <= state != IDLE;
            tx_done_o <= state == STOP && bit_end;
            if (take) begin
                div_max  <= div_sel;
                div_cnt  <= div_sel;
                tick_cnt <= '0;
                bit_idx  <= '0;
                shift    <= next_byte;
            end else if (state != IDLE) begin
                div_cnt  <= tick ? div_max : div_cnt - 9'd1;
                tick_cnt <= tick ? tick_cnt + 4'd1 : tick_cnt;
                if (state == DATA && bit_end) begin
                    shift   <= shift >> 1;
                    bit_idx <= bit_idx + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx; accepted bytes are queued and checked bit by bit on the line
// Covers the UART_TX_FIFO_EN build as well when that macro is defined.
`timescale 1ns/1ps
module tb_uart_tx;

    logic       clk_i = 1'b0;
    logic       rst_n;
    logic [2:0] buad_set_i;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_ready_o, uart_tx_o, tx_busy_o, tx_done_o;

    typedef struct {
        logic [7:0] d;
        int         p;
        int         acc;
    } exp_t;

    exp_t q[$];
    int   starts[$];
    int   cyc = 0, n_checks = 0, n_fail = 0;
    int   frames = 0, aborted = 0, done_total = 0, last_done = -1, last_end = -1;
    bit   in_frame = 1'b0;

    uart_tx dut (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .buad_set_i (buad_set_i),
        .tx_data_i  (tx_data_i),
        .tx_valid_i (tx_valid_i),
        .tx_ready_o (tx_ready_o),
        .uart_tx_o  (uart_tx_o),
        .tx_busy_o  (tx_busy_o),
        .tx_done_o  (tx_done_o)
    );

    always #10 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic int period(input logic [2:0] s);
        return s == 3'd1 ? 5200 : s == 3'd2 ? 2592 : s == 3'd3 ? 1296 : s == 3'd4 ? 864 : 432;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_n && tx_valid_i && tx_ready_o) q.push_back('{tx_data_i, period(buad_set_i), cyc + 1});
        if (rst_n && tx_done_o) begin
            done_total <= done_total + 1;
            last_done  <= cyc;
        end
    end

    task automatic run_frame();
        exp_t       e;
        logic [9:0] fr;
        int         ok, dn, bz, b;
        check("frame_expected", int'(q.size() > 0), 1);
        e = q.size() > 0 ? q.pop_front() : '{8'h00, 432, 0};
        in_frame = 1'b1;
        if (e.acc > last_end) check($sformatf("%02h_start_latency", e.d), cyc - e.acc, 1);
        starts.push_back(cyc);
        fr = {1'b1, e.d, 1'b0};
        ok = 0;
        dn = 0;
        bz = 0;
        for (int j = 0; j < 10 * e.p; j++) begin
            if (j > 0) @(negedge clk_i);
            if (!rst_n) begin
                aborted++;
                last_end = cyc;
                in_frame = 1'b0;
                return;
            end
            b = j / e.p;
            ok += int'(uart_tx_o == fr[b]);
            bz += int'(tx_busy_o);
            if (j < 10 * e.p - 1) dn += int'(tx_done_o);
            if (j % e.p == e.p - 1) begin
                check($sformatf("%02h_bit%0d_cycles", e.d, b), ok, e.p);
                ok = 0;
            end
        end
        check($sformatf("%02h_done_last", e.d), int'(tx_done_o), 1);
        check($sformatf("%02h_done_early", e.d), dn, 0);
        check($sformatf("%02h_busy_cycles", e.d), bz, 10 * e.p);
        frames++;
        last_end = cyc;
        in_frame = 1'b0;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk_i);
            if (rst_n && !uart_tx_o) run_frame();
        end
    end

    task automatic send(input logic [7:0] d);
        int n = 0;
        tx_data_i  = d;
        tx_valid_i = 1'b1;
        forever begin
            @(negedge clk_i);
            if (tx_ready_o || n >= 60000) break;
            n++;
        end
        check($sformatf("%02h_send_timeout", d), int'(n < 60000), 1);
        @(posedge clk_i);
        #1;
        tx_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        repeat (2) @(negedge clk_i);
        while ((tx_busy_o || in_frame || q.size() > 0) && n < 60000) begin
            @(negedge clk_i);
            n++;
        end
        check("idle_timeout", int'(n < 60000), 1);
        @(posedge clk_i);
        #1;
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: observed cycle %0d, expected finish before it", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int g, n;
        rst_n      = 1'b0;
        tx_valid_i = 1'b0;
        tx_data_i  = 8'h00;
        buad_set_i = 3'd5;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_line", int'(uart_tx_o), 1);
        check("rst_busy", int'(tx_busy_o), 0);
        check("rst_done", int'(tx_done_o), 0);
        check("rst_ready", int'(tx_ready_o), 1);
        rst_n = 1'b1;
        @(posedge clk_i);
        #1;

        send(8'h55);
        wait_idle();

        buad_set_i = 3'd1;
        send(8'hA5);
        wait_idle();

        buad_set_i = 3'd5;
        send(8'h0F);
        repeat (432 * 3) @(posedge clk_i);
        #1;
        buad_set_i = 3'd4;
`ifdef UART_TX_FIFO_EN
        check("ready_busy", int'(tx_ready_o), 1);
        send(8'h3C);
`else
        check("ready_busy", int'(tx_ready_o), 0);
        send(8'h3C);
        g = cyc - last_done;
        check("hold_accept_gap", int'(g >= 1 && g <= 2), 1);
`endif
        wait_idle();

        buad_set_i = 3'd5;
        send(8'h96);
        repeat (432 * 4 + 216) @(posedge clk_i);
        @(negedge clk_i);
        check("pre_reset_line", int'(uart_tx_o), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_line", int'(uart_tx_o), 1);
        check("async_rst_busy", int'(tx_busy_o), 0);
        check("async_rst_done", int'(tx_done_o), 0);
        check("async_rst_ready", int'(tx_ready_o), 1);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_n = 1'b1;
        @(posedge clk_i);
        #1;
        check("aborted_frames", aborted, 1);
        check("queue_after_reset", q.size(), 0);

`ifdef UART_TX_FIFO_EN
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        check("ready_after_4", int'(tx_ready_o), 1);
        send(8'h55);
        check("ready_after_5", int'(tx_ready_o), 0);
        wait_idle();
        n = starts.size();
        check("fifo_contiguous", starts[n - 1] - starts[n - 5], 4 * 4320);
        check("frames_total", frames, 9);
`else
        send(8'hC3);
        wait_idle();
        check("frames_total", frames, 5);
`endif
        check("done_total", done_total, frames);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
